// File: rtl/flag_stack_register.sv
// Processor status register: masked ALU load, explicit set/clear and a
// hardware save/restore stack for CALL/RET and interrupt entry/exit.
module flag_stack_register #(
    parameter int FLAG_W = 4,
    parameter int DEPTH  = 4,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLAG_W-1:0] flags_in,
    input  logic              load,
    input  logic [FLAG_W-1:0] load_mask,
    input  logic [FLAG_W-1:0] set_mask,
    input  logic [FLAG_W-1:0] clr_mask,
    input  logic              push,
    input  logic              pop,
    input  logic              err_clr,
    output logic [FLAG_W-1:0] flags_out,
    output logic [LW-1:0]     level,
    output logic              full,
    output logic              empty,
    output logic              ovf,
    output logic              unf
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [FLAG_W-1:0] r_flags;
    logic [LW-1:0]     r_level;
    logic              r_ovf;
    logic              r_unf;
    logic [FLAG_W-1:0] r_stack [0:(2**IW)-1];

    logic              w_full;
    logic              w_empty;
    logic              w_pushOk;
    logic              w_popOk;
    logic              w_pushErr;
    logic              w_popErr;
    logic [LW-1:0]     w_levelDec;
    logic [IW-1:0]     w_pushIdx;
    logic [IW-1:0]     w_popIdx;
    logic [FLAG_W-1:0] w_loaded;
    logic [FLAG_W-1:0] w_updated;

    assign w_full     = (r_level == LW'(DEPTH));
    assign w_empty    = (r_level == '0);

    // Simultaneous push and pop is illegal: it leaves the stack alone and
    // raises both sticky errors.
    assign w_pushOk   = push & ~pop & ~w_full;
    assign w_popOk    = pop & ~push & ~w_empty;
    assign w_pushErr  = push & (pop | w_full);
    assign w_popErr   = pop & (push | w_empty);

    assign w_levelDec = r_level - LW'(1);
    assign w_pushIdx  = r_level[IW-1:0];
    assign w_popIdx   = w_levelDec[IW-1:0];

    always_comb begin
        w_loaded  = load ? ((r_flags & ~load_mask) | (flags_in & load_mask)) : r_flags;
        w_updated = (w_loaded & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (w_popOk) begin
                r_flags <= r_stack[w_popIdx];
                r_level <= w_levelDec;
            end else begin
                r_flags <= w_updated;
                if (w_pushOk) begin
                    r_level <= r_level + LW'(1);
                end
            end
            r_ovf <= w_pushErr | (r_ovf & ~err_clr);
            r_unf <= w_popErr | (r_unf & ~err_clr);
        end
    end

    // Stack storage carries no reset; level alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (!rst && w_pushOk) begin
            r_stack[w_pushIdx] <= r_flags;
        end
    end

    assign flags_out = r_flags;
    assign level     = r_level;
    assign full      = w_full;
    assign empty     = w_empty;
    assign ovf       = r_ovf;
    assign unf       = r_unf;

endmodule

// File: tb/tb_flag_stack_register.sv
// Scoreboard bench for flag_stack_register: a behavioural model predicts each
// cycle's outputs, which are queued at drive time and compared after the edge.
module tb_flag_stack_register;

    localparam int FW = 4;
    localparam int DP = 4;
    localparam int LW = $clog2(DP + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] flags_in, load_mask, set_mask, clr_mask;
    logic          load, push, pop, err_clr;
    logic [FW-1:0] flags_out;
    logic [LW-1:0] level;
    logic          full, empty, ovf, unf;

    flag_stack_register #(.FLAG_W(FW), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst), .flags_in(flags_in), .load(load),
        .load_mask(load_mask), .set_mask(set_mask), .clr_mask(clr_mask),
        .push(push), .pop(pop), .err_clr(err_clr), .flags_out(flags_out),
        .level(level), .full(full), .empty(empty), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FW-1:0] flags;
        logic [LW-1:0] level;
        logic          full;
        logic          empty;
        logic          ovf;
        logic          unf;
    } ExpT;

    ExpT           expQ[$];
    logic [FW-1:0] mStack[$];
    logic [FW-1:0] mFlags = '0;
    logic          mOvf   = 1'b0;
    logic          mUnf   = 1'b0;
    int            assertCount = 0;
    int            failCount   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Reference model: advance one clock with the given inputs and queue the result.
    task automatic modelStep(input logic iRst, input logic iLoad, input logic [FW-1:0] iLm,
                             input logic [FW-1:0] iFin, input logic [FW-1:0] iSet,
                             input logic [FW-1:0] iClr, input logic iPush, input logic iPop,
                             input logic iErrClr);
        ExpT           e;
        logic [FW-1:0] t;
        logic [FW-1:0] nxt;
        logic          isFull, isEmpty, newOvf, newUnf;
        if (iRst) begin
            mFlags = '0;
            mStack.delete();
            mOvf = 1'b0;
            mUnf = 1'b0;
        end else begin
            isFull  = (mStack.size() == DP);
            isEmpty = (mStack.size() == 0);
            t   = iLoad ? ((mFlags & ~iLm) | (iFin & iLm)) : mFlags;
            nxt = (t & ~iClr) | iSet;
            newOvf = iPush && (iPop || isFull);
            newUnf = iPop && (iPush || isEmpty);
            if (iPop && !iPush && !isEmpty) nxt = mStack.pop_back();
            if (iPush && !iPop && !isFull) mStack.push_back(mFlags);
            mFlags = nxt;
            mOvf = newOvf || (mOvf && !iErrClr);
            mUnf = newUnf || (mUnf && !iErrClr);
        end
        e.flags = mFlags;
        e.level = LW'(mStack.size());
        e.full  = (mStack.size() == DP);
        e.empty = (mStack.size() == 0);
        e.ovf   = mOvf;
        e.unf   = mUnf;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input string tag, input logic iRst, input logic iLoad,
                                 input logic [FW-1:0] iLm, input logic [FW-1:0] iFin,
                                 input logic [FW-1:0] iSet, input logic [FW-1:0] iClr,
                                 input logic iPush, input logic iPop, input logic iErrClr);
        ExpT e;
        @(negedge clk);
        rst = iRst; load = iLoad; load_mask = iLm; flags_in = iFin;
        set_mask = iSet; clr_mask = iClr; push = iPush; pop = iPop; err_clr = iErrClr;
        modelStep(iRst, iLoad, iLm, iFin, iSet, iClr, iPush, iPop, iErrClr);
        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            checkOutput({tag, " queue"}, 32'(1), 32'(0));
        end else begin
            e = expQ.pop_front();
            checkOutput({tag, " flags"}, 32'(flags_out), 32'(e.flags));
            checkOutput({tag, " level"}, 32'(level), 32'(e.level));
            checkOutput({tag, " full"}, 32'(full), 32'(e.full));
            checkOutput({tag, " empty"}, 32'(empty), 32'(e.empty));
            checkOutput({tag, " ovf"}, 32'(ovf), 32'(e.ovf));
            checkOutput({tag, " unf"}, 32'(unf), 32'(e.unf));
        end
    endtask

    task automatic idle(input string tag);
        applyStimulus(tag, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic loadAll(input string tag, input logic [FW-1:0] v, input logic iPush, input logic iPop);
        applyStimulus(tag, 1'b0, 1'b1, 4'hF, v, '0, '0, iPush, iPop, 1'b0);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; load_mask = '0; flags_in = '0;
        set_mask = '0; clr_mask = '0; push = 1'b0; pop = 1'b0; err_clr = 1'b0;

        applyStimulus("reset", 1'b1, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset empty", 32'(empty), 32'(1));

        // Masked load, then set beating clear on the same bit
        applyStimulus("mload", 1'b0, 1'b1, 4'b0011, 4'b1111, '0, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("mload value", 32'(flags_out), 32'(4'b0011));
        applyStimulus("setclr", 1'b0, 1'b0, '0, '0, 4'b1000, 4'b1001, 1'b0, 1'b0, 1'b0);
        checkOutput("setclr value", 32'(flags_out), 32'(4'b1010));

        // Save, clobber, restore
        loadAll("ld0101", 4'b0101, 1'b0, 1'b0);
        applyStimulus("push1", 1'b0, 1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("push1 level", 32'(level), 32'(1));
        loadAll("ld0000", 4'b0000, 1'b0, 1'b0);
        applyStimulus("pop1", 1'b0, 1'b1, 4'hF, 4'b1111, 4'b1111, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("pop1 restored", 32'(flags_out), 32'(4'b0101));

        // Fill to DEPTH, overflow, then drain in LIFO order
        loadAll("ld1", 4'd1, 1'b0, 1'b0);
        loadAll("push-ld2", 4'd2, 1'b1, 1'b0);
        loadAll("push-ld3", 4'd3, 1'b1, 1'b0);
        loadAll("push-ld4", 4'd4, 1'b1, 1'b0);
        loadAll("push-ld0", 4'd0, 1'b1, 1'b0);
        checkOutput("fill full", 32'(full), 32'(1));
        loadAll("push-ovf", 4'd9, 1'b1, 1'b0);
        checkOutput("ovf level", 32'(level), 32'(4));
        checkOutput("ovf flag", 32'(ovf), 32'(1));
        for (int i = 0; i < DP; i++) applyStimulus("drain", 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("drain last", 32'(flags_out), 32'(1));
        applyStimulus("errclr", 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1);

        // Underflow with concurrent load, err_clr racing a new error
        applyStimulus("unf-load", 1'b0, 1'b1, 4'hF, 4'b0110, '0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("unf flags", 32'(flags_out), 32'(4'b0110));
        applyStimulus("unf-race", 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
        checkOutput("unf sticky", 32'(unf), 32'(1));
        applyStimulus("unf-clr", 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("unf cleared", 32'(unf), 32'(0));

        // Push and pop together at level 2
        loadAll("l2a", 4'd7, 1'b1, 1'b0);
        loadAll("l2b", 4'd8, 1'b1, 1'b0);
        applyStimulus("pushpop", 1'b0, 1'b1, 4'b0011, 4'b0001, 4'b0100, 4'b1000, 1'b1, 1'b1, 1'b0);
        checkOutput("pushpop level", 32'(level), 32'(2));
        checkOutput("pushpop flags", 32'(flags_out), 32'(4'b0101));
        applyStimulus("pushpop-clr", 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1);

        // Reset mid-push at level 3 discards the stack
        loadAll("l3", 4'd3, 1'b1, 1'b0);
        applyStimulus("rst-push", 1'b1, 1'b1, 4'hF, 4'hA, '0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("rst level", 32'(level), 32'(0));
        applyStimulus("rst-pop", 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("rst-pop unf", 32'(unf), 32'(1));

        // Back-to-back alternating push/pop
        for (int i = 0; i < 6; i++) loadAll("alt", 4'(i + 5), (i % 2) == 0, (i % 2) == 1);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            applyStimulus("rand", ($urandom_range(0, 40) == 0), 1'($urandom), 4'($urandom),
                          4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
                          ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
                          ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 5) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
